// File: rtl/rr_priority_arbiter.sv
// ============================================================================
// Module   : rr_priority_arbiter
// Purpose  : Registered N-way request arbiter built around a wrap-around
//            priority encoder. One requester is selected and held as a
//            one-hot grant plus its binary index until the consumer
//            acknowledges it or the requester withdraws. The arbiter then
//            returns to IDLE for one cycle and arbitrates again.
//            ROUND_ROBIN=1 : the search starts at a rotating pointer.
//            ROUND_ROBIN=0 : the search always starts at bit 0 (LSB wins).
// Ports    : clk         - rising-edge clock
//            rst_n       - asynchronous active-low reset
//            req_i[N]    - request vector, bit i = requester i
//            ack_i       - consumer accepts the held grant
//            gnt_valid_o - a grant is being held
//            gnt_o[N]    - one-hot grant, zero when not valid
//            gnt_idx_o   - index of the granted requester, zero when not valid
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_arbiter #(
  parameter int N           = 8,
  parameter int ROUND_ROBIN = 1,
  parameter int IDXW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_i,
  input  logic            ack_i,
  output logic            gnt_valid_o,
  output logic [N-1:0]    gnt_o,
  output logic [IDXW-1:0] gnt_idx_o
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [N-1:0]    gnt_q, gnt_d;

  logic [IDXW-1:0] search_start;
  logic [IDXW-1:0] ptr_after_ack;
  logic [IDXW-1:0] win_idx;
  logic            win_found;
  logic [IDXW:0]   scan_sum;
  logic [IDXW-1:0] scan_pos;

  // --------------------------------------------------------------------------
  // Search start and pointer advance. In fixed mode both collapse to zero so
  // the pointer register never leaves 0.
  // --------------------------------------------------------------------------
  generate
    if (ROUND_ROBIN != 0) begin : g_rr_ptr
      assign search_start  = ptr_q;
      // Wrap at N-1, not at 2^IDXW-1, so non-power-of-two N stays in range.
      assign ptr_after_ack = (idx_q == IDXW'(N - 1)) ? '0 : idx_q + IDXW'(1);
    end else begin : g_fixed_ptr
      assign search_start  = '0;
      assign ptr_after_ack = '0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Wrap-around priority encoder: scan positions start, start+1, ... modulo N
  // and keep the first requester found. The sum needs one extra bit because
  // start + k can reach 2N-2 before the wrap subtraction.
  // --------------------------------------------------------------------------
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_pos  = '0;
    for (int k = 0; k < N; k++) begin
      scan_sum = {1'b0, search_start} + (IDXW+1)'(k);
      if (scan_sum >= (IDXW+1)'(N)) begin
        scan_sum = scan_sum - (IDXW+1)'(N);
      end
      scan_pos = scan_sum[IDXW-1:0];
      if (!win_found && req_i[scan_pos]) begin
        win_found = 1'b1;
        win_idx   = scan_pos;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d        = ST_GRANT;
          idx_d          = win_idx;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
        end
      end
      ST_GRANT: begin
        // Ack takes precedence over a simultaneous withdrawal, so the
        // pointer still advances when the request has already dropped.
        if (ack_i) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          gnt_d   = '0;
          ptr_d   = ptr_after_ack;
        end else if (!req_i[idx_q]) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        gnt_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
    end
  end

  // Outputs come straight from registers; no input-to-output path exists.
  assign gnt_valid_o = (state_q == ST_GRANT);
  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = idx_q;

  // --------------------------------------------------------------------------
  // Invariants
  // --------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt_q) && ($onehot(gnt_q) == gnt_valid_o));

  a_gnt_idx_match: assert property (@(posedge clk) disable iff (!rst_n)
    gnt_valid_o |-> gnt_q[idx_q]);

  generate
    if (ROUND_ROBIN == 0) begin : g_fixed_chk
      logic [N-1:0] below_win;
      always_comb begin
        below_win = '0;
        for (int i = 0; i < N; i++) begin
          below_win[i] = (IDXW'(i) < win_idx);
        end
      end
      a_lowest_wins: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_IDLE && win_found) |-> ((req_i & below_win) == '0));
    end
  endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_rr_priority_arbiter.sv
// ============================================================================
// Module   : tb_rr_priority_arbiter
// Purpose  : Self-checking bench for rr_priority_arbiter. Five instances
//            (fixed N=8, round-robin N=8/5/3/1) share clock and reset.
//            Stimulus pushes hand-computed grant indices into per-instance
//            queues; a monitor pops one entry on every rising gnt_valid_o.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_priority_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [7:0] req_f8, req_r8;
  logic [4:0] req_r5;
  logic [2:0] req_r3;
  logic [0:0] req_r1;
  logic       ack_f8, ack_r8, ack_r5, ack_r3, ack_r1;

  logic       v_f8, v_r8, v_r5, v_r3, v_r1;
  logic [7:0] g_f8, g_r8;
  logic [4:0] g_r5;
  logic [2:0] g_r3;
  logic [0:0] g_r1;
  logic [2:0] i_f8, i_r8, i_r5;
  logic [1:0] i_r3;
  logic [0:0] i_r1;

  rr_priority_arbiter #(.N(8), .ROUND_ROBIN(0)) u_f8 (
    .clk(clk), .rst_n(rst_n), .req_i(req_f8), .ack_i(ack_f8),
    .gnt_valid_o(v_f8), .gnt_o(g_f8), .gnt_idx_o(i_f8));
  rr_priority_arbiter #(.N(8), .ROUND_ROBIN(1)) u_r8 (
    .clk(clk), .rst_n(rst_n), .req_i(req_r8), .ack_i(ack_r8),
    .gnt_valid_o(v_r8), .gnt_o(g_r8), .gnt_idx_o(i_r8));
  rr_priority_arbiter #(.N(5), .ROUND_ROBIN(1)) u_r5 (
    .clk(clk), .rst_n(rst_n), .req_i(req_r5), .ack_i(ack_r5),
    .gnt_valid_o(v_r5), .gnt_o(g_r5), .gnt_idx_o(i_r5));
  rr_priority_arbiter #(.N(3), .ROUND_ROBIN(1)) u_r3 (
    .clk(clk), .rst_n(rst_n), .req_i(req_r3), .ack_i(ack_r3),
    .gnt_valid_o(v_r3), .gnt_o(g_r3), .gnt_idx_o(i_r3));
  rr_priority_arbiter #(.N(1), .ROUND_ROBIN(1)) u_r1 (
    .clk(clk), .rst_n(rst_n), .req_i(req_r1), .ack_i(ack_r1),
    .gnt_valid_o(v_r1), .gnt_o(g_r1), .gnt_idx_o(i_r1));

  int n_checks = 0;
  int n_pass   = 0;

  // Expected grant indices, one queue per instance: 0=f8 1=r8 2=r5 3=r3 4=r1
  int q_f8[$], q_r8[$], q_r5[$], q_r3[$], q_r1[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic push(input int id, input int e);
    case (id)
      0: q_f8.push_back(e);
      1: q_r8.push_back(e);
      2: q_r5.push_back(e);
      3: q_r3.push_back(e);
      default: q_r1.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int id);
    case (id)
      0: return q_f8.size();
      1: return q_r8.size();
      2: return q_r5.size();
      3: return q_r3.size();
      default: return q_r1.size();
    endcase
  endfunction

  task automatic qflush(input int id);
    case (id)
      0: q_f8.delete();
      1: q_r8.delete();
      2: q_r5.delete();
      3: q_r3.delete();
      default: q_r1.delete();
    endcase
  endtask

  task automatic on_grant(input int id, input string nm, input int idx, input int gnt);
    int e;
    bit have;
    e    = 0;
    have = 1'b0;
    case (id)
      0: if (q_f8.size() > 0) begin e = q_f8.pop_front(); have = 1'b1; end
      1: if (q_r8.size() > 0) begin e = q_r8.pop_front(); have = 1'b1; end
      2: if (q_r5.size() > 0) begin e = q_r5.pop_front(); have = 1'b1; end
      3: if (q_r3.size() > 0) begin e = q_r3.pop_front(); have = 1'b1; end
      default: if (q_r1.size() > 0) begin e = q_r1.pop_front(); have = 1'b1; end
    endcase
    n_checks++;
    if (!have) begin
      $display("FAIL %s unexpected grant: got idx %0d, expected no grant", nm, idx);
    end else if (idx == e && gnt == (1 << e)) begin
      n_pass++;
    end else begin
      $display("FAIL %s grant: got idx %0d gnt 0x%0h, expected idx %0d gnt 0x%0h",
               nm, idx, gnt, e, 1 << e);
    end
  endtask

  // Monitor: one scoreboard pop per rising edge of gnt_valid_o.
  logic pv_f8 = 1'b0, pv_r8 = 1'b0, pv_r5 = 1'b0, pv_r3 = 1'b0, pv_r1 = 1'b0;
  always @(negedge clk) begin
    if (v_f8 && !pv_f8) on_grant(0, "f8", int'(i_f8), int'(g_f8));
    if (v_r8 && !pv_r8) on_grant(1, "r8", int'(i_r8), int'(g_r8));
    if (v_r5 && !pv_r5) on_grant(2, "r5", int'(i_r5), int'(g_r5));
    if (v_r3 && !pv_r3) on_grant(3, "r3", int'(i_r3), int'(g_r3));
    if (v_r1 && !pv_r1) on_grant(4, "r1", int'(i_r1), int'(g_r1));
    pv_f8 <= v_f8;
    pv_r8 <= v_r8;
    pv_r5 <= v_r5;
    pv_r3 <= v_r3;
    pv_r1 <= v_r1;
  end

  // Returns at negedge+1 of the last expected grant, or after a bounded wait.
  task automatic wait_empty(input int id, input string nm);
    int c;
    c = 0;
    while (qsize(id) != 0 && c < 200) begin
      @(negedge clk); #1;
      c++;
    end
    if (qsize(id) != 0) begin
      n_checks++;
      $display("FAIL %s timeout: got %0d grants outstanding, expected 0", nm, qsize(id));
      qflush(id);
    end
  endtask

  // Lets the pending ack/withdraw edge and one idle edge pass.
  task automatic gap();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    req_f8 = '0; req_r8 = '0; req_r5 = '0; req_r3 = '0; req_r1 = '0;
    ack_f8 = 1'b0; ack_r8 = 1'b0; ack_r5 = 1'b0; ack_r3 = 1'b0; ack_r1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset r8 valid", int'(v_r8), 0);
    chk("reset r8 gnt",   int'(g_r8), 0);
    chk("reset r8 idx",   int'(i_r8), 0);
    chk("reset f8 valid", int'(v_f8), 0);
    chk("reset r5 valid", int'(v_r5), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fixed priority: lowest set bit always wins, pointer plays no part.
    push(0, 2); push(0, 2); push(0, 2);
    req_f8 = 8'b1010_0100; ack_f8 = 1'b1;
    wait_empty(0, "f8 lsb");
    req_f8 = '0; gap();
    push(0, 5); push(0, 5);
    req_f8 = 8'b1010_0000;
    wait_empty(0, "f8 drop2");
    req_f8 = '0; gap();
    push(0, 0);
    req_f8 = 8'hFF;
    wait_empty(0, "f8 all");
    req_f8 = '0; gap();

    // Round robin N=8, all requesting: 0..7 then wrap to 0, valid toggles.
    for (int k = 0; k < 8; k++) push(1, k);
    push(1, 0);
    req_r8 = 8'hFF; ack_r8 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("r8 valid pattern", int'(v_r8), k % 2);
    end
    wait_empty(1, "r8 sweep");
    req_r8 = '0; gap();                      // ptr = 1

    push(1, 2);
    req_r8 = 8'h04;
    wait_empty(1, "r8 set ptr");
    req_r8 = '0; gap();                      // ptr = 3

    // Withdrawal: drop the granted request without ack.
    push(1, 3);
    req_r8 = 8'h08; ack_r8 = 1'b0;
    wait_empty(1, "r8 withdraw grant");
    req_r8 = '0;
    @(negedge clk); #1;
    chk("r8 withdraw valid", int'(v_r8), 0);
    chk("r8 withdraw gnt",   int'(g_r8), 0);
    push(1, 3);                              // ptr still 3
    req_r8 = 8'hFF; ack_r8 = 1'b1;
    wait_empty(1, "r8 after withdraw");
    req_r8 = '0; gap();                      // ptr = 4

    // Hold: other requests appear while grant 1 is held without ack.
    push(1, 1);
    req_r8 = 8'h02; ack_r8 = 1'b0;
    wait_empty(1, "r8 hold grant");
    req_r8 = 8'h82;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      chk("r8 hold gnt", int'(g_r8), 8'h02);
    end
    chk("r8 hold idx", int'(i_r8), 1);
    ack_r8 = 1'b1; req_r8 = '0; gap();      // ptr = 2

    // Asynchronous reset during a grant.
    push(1, 2);
    req_r8 = 8'hFF; ack_r8 = 1'b0;
    wait_empty(1, "r8 pre-reset grant");
    rst_n = 1'b0;
    #1;
    chk("async reset valid", int'(v_r8), 0);
    chk("async reset gnt",   int'(g_r8), 0);
    chk("async reset idx",   int'(i_r8), 0);
    push(1, 0);
    ack_r8 = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_empty(1, "r8 post-reset");
    req_r8 = '0; gap();

    // Round robin N=5: wrap from pointer 4 back to 0, never index >= 5.
    push(2, 3);
    req_r5 = 5'b01000; ack_r5 = 1'b1;
    wait_empty(2, "r5 set ptr");
    req_r5 = '0; gap();                      // ptr = 4
    push(2, 0); push(2, 1); push(2, 0);
    req_r5 = 5'b00011;
    wait_empty(2, "r5 wrap");
    req_r5 = '0; gap();

    // Round robin N=3.
    push(3, 0); push(3, 1); push(3, 2); push(3, 0);
    req_r3 = 3'b111; ack_r3 = 1'b1;
    wait_empty(3, "r3 sweep");
    req_r3 = '0; gap();

    // N=1: index is always 0.
    push(4, 0); push(4, 0);
    req_r1 = 1'b1; ack_r1 = 1'b1;
    wait_empty(4, "r1 repeat");
    req_r1 = '0; gap();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
